// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery multiplier sequencer: FSM state
// encoding and the default operand width.
package mmm_pkg;

    localparam int MMM_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRECOMP = 2'd1,
        ST_ITER    = 2'd2,
        ST_DONE    = 2'd3
    } mmm_state_e;

endpackage

// File: rtl/mmm_serial_adder.sv
// Bit-serial full adder used to form m+b one bit per cycle, LSB first.
// The carry flop clears synchronously on reset or on an explicit clear.
module mmm_serial_adder
    import mmm_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    input  logic y,
    output logic sum,
    output logic cout
);

    logic carry_q;

    assign sum  = x ^ y ^ carry_q;
    assign cout = (x & y) | (x & carry_q) | (y & carry_q);

    // Carry flop: cleared at the start of each addition, advances while enabled.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample pre-edge values.
        if (!rst_n || clr) begin
            carry_q <= 1'b0;
        end else if (en) begin
            carry_q <= cout;
        end
    end

endmodule

// File: rtl/mmm_sequencer.sv
// Control sequencer for a bit-serial Montgomery multiplier PE array.
// Captures operands on start, optionally precomputes m+b serially, then
// steps the PE array for WIDTH iterations and pulses done.
// Build option: define MMM_SEQ_PRECOMP_EN to include the PRECOMP phase and
// serial adder; otherwise IDLE goes straight to ITER and mb is tied to 0.
module mmm_sequencer
    import mmm_pkg::*;
#(
    parameter int WIDTH = MMM_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic             r0,
    output logic             ai,
    output logic             qi,
    output logic             step,
    output logic [WIDTH:0]   mb,
    output logic             busy,
    output logic             done
);

    localparam int             CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    mmm_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic             b0_q;
    logic             cnt_last;
    logic             accept;

    assign cnt_last = (cnt_q == CNT_LAST);
    assign accept   = (state_q == ST_IDLE) && start;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
`ifdef MMM_SEQ_PRECOMP_EN
                    state_d = ST_PRECOMP;
`else
                    state_d = ST_ITER;
`endif
                end
            end
`ifdef MMM_SEQ_PRECOMP_EN
            ST_PRECOMP: if (cnt_last) state_d = ST_ITER;
`endif
            ST_ITER:    if (cnt_last) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output decode; everything is forced low while reset is held.
    always_comb begin
        ai   = 1'b0;
        qi   = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        if (rst_n) begin
            busy = (state_q != ST_IDLE);
            done = (state_q == ST_DONE);
            if (state_q == ST_ITER) begin
                step = 1'b1;
                ai   = a_sh_q[0];
                qi   = r0 ^ (a_sh_q[0] & b0_q);
            end
        end
    end

    // Phase counter and multiplier-bit shift register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            a_sh_q <= '0;
            b0_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q  <= '0;
                        a_sh_q <= a;
                        b0_q   <= b[0];
                    end
                end
`ifdef MMM_SEQ_PRECOMP_EN
                ST_PRECOMP: cnt_q <= cnt_last ? '0 : cnt_q + CW'(1);
`endif
                ST_ITER: begin
                    cnt_q  <= cnt_last ? '0 : cnt_q + CW'(1);
                    a_sh_q <= a_sh_q >> 1;
                end
                default: ;
            endcase
        end
    end

`ifdef MMM_SEQ_PRECOMP_EN
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] m_sh_q;
    logic [WIDTH:0]   mb_q;
    logic             add_sum;
    logic             add_cout;

    mmm_serial_adder u_adder (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .en    (state_q == ST_PRECOMP),
        .x     (m_sh_q[0]),
        .y     (b_sh_q[0]),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    // Serial m+b: operands shift out LSB first, sum bits enter mb at the MSB end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            b_sh_q <= '0;
            m_sh_q <= '0;
            mb_q   <= '0;
        end else if (accept) begin
            b_sh_q <= b;
            m_sh_q <= m;
            mb_q   <= '0;
        end else if (state_q == ST_PRECOMP) begin
            b_sh_q           <= b_sh_q >> 1;
            m_sh_q           <= m_sh_q >> 1;
            mb_q[WIDTH-1:0]  <= {add_sum, mb_q[WIDTH-1:1]};
            if (cnt_last) begin
                mb_q[WIDTH] <= add_cout;
            end
        end
    end

    assign mb = rst_n ? mb_q : '0;
`else
    // m and the upper bits of b only feed the precompute path.
    logic unused_precomp_inputs;
    assign unused_precomp_inputs = ^{m, b[WIDTH-1:1]};

    assign mb = '0;
`endif

endmodule

// File: tb/tb_mmm_sequencer.sv
// Self-checking bench for mmm_sequencer: a cycle-offset reference model
// (outputs derived from "cycles since the accepting edge") checked every
// cycle, plus directed operations with hand-computed literal expectations.
module tb_mmm_sequencer;

    localparam int W = 8;
`ifdef MMM_SEQ_PRECOMP_EN
    localparam int P = W;
`else
    localparam int P = 0;
`endif
    localparam int EXP_LAT = P + W + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b, m;
    logic         r0;
    logic         ai, qi, step, busy, done;
    logic [W:0]   mb;

    mmm_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .m     (m),
        .r0    (r0),
        .ai    (ai),
        .qi    (qi),
        .step  (step),
        .mb    (mb),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an operation is "cycles since accept"; its phase follows
    // from the offset alone (precompute, W iterations, one done cycle).
    bit           md_active = 1'b0;
    int           md_off    = 0;
    logic [W-1:0] md_a      = '0;
    bit           md_b0     = 1'b0;
    logic [W:0]   md_mb     = '0;

    always @(posedge clk) begin
        if (rst_n !== 1'b1) begin
            md_active = 1'b0;
            md_mb     = '0;
        end else if (md_active) begin
            if (md_off == P + W + 1) md_active = 1'b0;
            else                     md_off++;
        end else if (start === 1'b1) begin
            md_active = 1'b1;
            md_off    = 1;
            md_a      = a;
            md_b0     = b[0];
`ifdef MMM_SEQ_PRECOMP_EN
            md_mb     = {1'b0, m} + {1'b0, b};
`else
            md_mb     = '0;
`endif
        end
    end

    // Per-cycle comparison of every output against the model.
    logic       e_ai, e_qi, e_step, e_busy, e_done;
    logic [W:0] e_mb;
    bit         chk_mb;
    int         it;

    always @(negedge clk) begin
        e_ai = 1'b0; e_qi = 1'b0; e_step = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        e_mb = md_mb; chk_mb = 1'b1;
        if (rst_n !== 1'b1) begin
            e_mb = '0;
        end else if (md_active) begin
            e_busy = 1'b1;
            if (md_off <= P) begin
                chk_mb = 1'b0;
            end else if (md_off <= P + W) begin
                it     = md_off - P - 1;
                e_step = 1'b1;
                e_ai   = md_a[it];
                e_qi   = r0 ^ (e_ai & md_b0);
            end else begin
                e_done = 1'b1;
            end
        end
        check("busy", 32'(busy), 32'(e_busy));
        check("done", 32'(done), 32'(e_done));
        check("step", 32'(step), 32'(e_step));
        check("ai",   32'(ai),   32'(e_ai));
        check("qi",   32'(qi),   32'(e_qi));
        if (chk_mb) check("mb", 32'(mb), 32'(e_mb));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: start, then watch until done (bounded), recording the
    // ai/qi bit sequences, step count and mb at the first iteration cycle.
    // Operand inputs are scrambled while busy; capture must hold.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] tm, input bit r0v, input bit hold_start,
                          output int lat, output logic [W-1:0] ai_seq,
                          output logic [W-1:0] qi_seq, output int nstep,
                          output logic [W:0] mb_first);
        a = ta; b = tb_v; m = tm; r0 = r0v; start = 1'b1;
        tick();
        start = hold_start;
        lat = 0; nstep = 0; ai_seq = '0; qi_seq = '0; mb_first = '1;
        for (int c = 1; c <= 4 * W + 8 && lat == 0; c++) begin
            a = W'($urandom); b = W'($urandom); m = W'($urandom);
            @(negedge clk);
            if (step === 1'b1) begin
                if (nstep == 0) mb_first = mb;
                if (nstep < W) begin
                    ai_seq[nstep] = ai;
                    qi_seq[nstep] = qi;
                end
                nstep++;
            end
            if (done === 1'b1) lat = c;
            tick();
        end
        start = 1'b0;
        @(negedge clk);
        check("idle after done busy", 32'(busy), 32'd0);
        tick();
    endtask

    int           lat, nstep, ndone;
    logic [W-1:0] ai_seq, qi_seq;
    logic [W:0]   mb_first;

    initial begin
        rst_n = 1'b0; start = 1'b0; r0 = 1'b0; a = '0; b = '0; m = '0;
        #1;
        repeat (3) tick();
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset mb",   32'(mb),   32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // m=0xC5, b=0x3A -> m+b = 0x0FF
        run_op(8'h11, 8'h3A, 8'hC5, 1'b0, 1'b0, lat, ai_seq, qi_seq, nstep, mb_first);
        check("lat c5+3a", 32'(lat), 32'(EXP_LAT));
`ifdef MMM_SEQ_PRECOMP_EN
        check("mb c5+3a", 32'(mb_first), 32'h0FF);
`else
        check("mb c5+3a", 32'(mb_first), 32'h000);
`endif

        // m=0xFF, b=0x01 -> carry lands in mb[8]
        run_op(8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, lat, ai_seq, qi_seq, nstep, mb_first);
`ifdef MMM_SEQ_PRECOMP_EN
        check("mb ff+01", 32'(mb_first), 32'h100);
`else
        check("mb ff+01", 32'(mb_first), 32'h000);
`endif

        // a=0xA5, b[0]=0, r0=0 -> ai 1,0,1,0,0,1,0,1 (LSB first), qi all 0
        run_op(8'hA5, 8'h3A, 8'h5C, 1'b0, 1'b0, lat, ai_seq, qi_seq, nstep, mb_first);
        check("ai seq a5",  32'(ai_seq), 32'hA5);
        check("qi seq b0=0", 32'(qi_seq), 32'h00);
        check("step count", 32'(nstep),  32'd8);

        // a=0xA5, b[0]=1: r0=1 -> qi = ~ai, r0=0 -> qi = ai
        run_op(8'hA5, 8'h3B, 8'h77, 1'b1, 1'b0, lat, ai_seq, qi_seq, nstep, mb_first);
        check("qi seq r0=1", 32'(qi_seq), 32'h5A);
        run_op(8'hA5, 8'h3B, 8'h77, 1'b0, 1'b0, lat, ai_seq, qi_seq, nstep, mb_first);
        check("qi seq r0=0", 32'(qi_seq), 32'hA5);

        // start held through PRECOMP/ITER/DONE: no restart, one done, idle after
        run_op(8'h3C, 8'h12, 8'h34, 1'b0, 1'b1, lat, ai_seq, qi_seq, nstep, mb_first);
        check("lat start held", 32'(lat), 32'(EXP_LAT));

        // reset in the 3rd ITER cycle aborts with no done pulse
        a = 8'h96; b = 8'h21; m = 8'h43; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (P + 2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd0);
        check("abort step", 32'(step), 32'd0);
        check("abort ai",   32'(ai),   32'd0);
        check("abort mb",   32'(mb),   32'd0);
        tick();
        ndone = 0;
        for (int c = 0; c < 2 * W + 6; c++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
            tick();
        end
        check("abort no done", 32'(ndone), 32'd0);
        run_op(8'h5A, 8'hC5, 8'h3A, 1'b1, 1'b0, lat, ai_seq, qi_seq, nstep, mb_first);
        check("lat after abort", 32'(lat), 32'(EXP_LAT));
        check("ai after abort",  32'(ai_seq), 32'h5A);

        // randomized traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            start = ($urandom_range(0, 3) == 0);
            rst_n = ($urandom_range(0, 63) != 0);
            r0    = 1'($urandom);
            a = W'($urandom); b = W'($urandom); m = W'($urandom);
            tick();
        end
        rst_n = 1'b1; start = 1'b0;
        repeat (3 * W) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mmm_sequencer.md
MMM_SEQUENCER -- requirements
Module: mmm_sequencer

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (>=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 start  input  1  begin a multiplication; sampled only in IDLE.
REQ-005 a  input  WIDTH  multiplier operand; captured on accepted start.
REQ-006 b  input  WIDTH  multiplicand; captured on accepted start.
REQ-007 m  input  WIDTH  modulus; captured on accepted start.
REQ-008 r0  input  1  LSB of the current partial result from the processing-element array.
REQ-009 ai  output  1  current multiplier bit, a select bit to the PE muxes.
REQ-010 qi  output  1  current quotient bit, a select bit to the PE muxes.
REQ-011 step  output  1  high on each iteration cycle; the PE array advances when step is high.
REQ-012 mb  output  WIDTH+1  precomputed m+b for the PE mbi inputs.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  single-cycle completion pulse.

Function
REQ-015 FSM states: IDLE, PRECOMP, ITER, DONE; cycle counter width clog2(WIDTH)+1.
REQ-016 IDLE: start=1 captures a, b, m; clears counter and carry; next state is PRECOMP.
REQ-017 PRECOMP: one bit of m+b per cycle, LSB first, through a serial full adder with a carry flop.
REQ-018 PRECOMP: sum bits shift into mb from the MSB end; after exactly WIDTH cycles the final carry is stored in mb[WIDTH]; next state is ITER.
REQ-019 ITER: lasts exactly WIDTH cycles; step=1 in each.
REQ-020 ITER: ai = captured a bit i (LSB first, i = 0..WIDTH-1) from an internal shift register.
REQ-021 ITER: qi = r0 XOR (ai AND b[0]), combinational from r0 in the same cycle.
REQ-022 After the WIDTH-th ITER cycle, next state is DONE.
REQ-023 DONE: one cycle; done=1, busy=1; next state is IDLE.
REQ-024 Latency: start accepted at edge k; PRECOMP cycles k+1..k+WIDTH; ITER cycles k+WIDTH+1..k+2*WIDTH; done high in cycle k+2*WIDTH+1.
REQ-025 start while busy is ignored; captured operands do not change.
REQ-026 Outside ITER: ai=0, qi=0, step=0, which selects 0 at the PE muxes.
REQ-027 mb holds its value from the first ITER cycle until the next accepted start.
REQ-028 Addition is modulo 2^(WIDTH+1); carry-out always lands in mb[WIDTH].
REQ-029 start asserted in the DONE cycle is ignored; start asserted in the following IDLE cycle is accepted.

Reset
REQ-030 rst_n=0 at a rising edge forces IDLE and clears the counter, carry, shift registers and mb; this applies in any state, including mid-PRECOMP and mid-ITER.
REQ-031 While in reset: ai=0, qi=0, step=0, busy=0, done=0, mb=0.
REQ-032 There is no done pulse for an aborted operation.

Configuration
REQ-033 Macro MMM_SEQ_PRECOMP_EN, when defined, includes PRECOMP and the serial adder as described above.
REQ-034 Without MMM_SEQ_PRECOMP_EN: IDLE goes directly to ITER; mb is tied to 0; mbi must be supplied externally; done rises in cycle k+WIDTH+1.

Structure
REQ-035 Shared package mmm_pkg holds the FSM state encoding (2-bit: IDLE=0, PRECOMP=1, ITER=2, DONE=3) and the default WIDTH constant.
REQ-036 One sub-module, mmm_serial_adder (1-bit full adder plus carry flop with synchronous clear), is instantiated for PRECOMP.

Verification
REQ-037 WIDTH=8, m=0xC5, b=0x3A, start -> mb=0x0FF at the first ITER cycle; done at start-edge+17.
REQ-038 m=0xFF, b=0x01 -> mb=0x100, exercising the carry into mb[WIDTH].
REQ-039 a=0xA5, b[0]=0, r0=0 -> ai sequence 1,0,1,0,0,1,0,1; qi all 0; step high for exactly 8 cycles.
REQ-040 a=0xA5, b[0]=1, r0=1 -> qi = NOT ai in each ITER cycle; with r0=0, qi = ai.
REQ-041 start pulsed during PRECOMP and again in the DONE cycle -> both ignored; exactly one done pulse per accepted start.
REQ-042 rst_n=0 in the 3rd ITER cycle -> next cycle in IDLE, all outputs 0, no done pulse; a fresh start then completes normally. Repeat with MMM_SEQ_PRECOMP_EN undefined -> done at start-edge+9, mb=0.
